// File: rtl/job_dispatcher_if.sv
// Client/counter-facing channel of job_dispatcher: request queue, start handshake, completion report.
interface job_dispatcher_if #(
  parameter int TAG_WIDTH = 4,
  parameter int PEND_W    = 3
);
  logic                 request__ENA;
  logic [TAG_WIDTH-1:0] request_tag;
  logic                 request__RDY;
  logic                 startSignal__ENA;
  logic                 startSignal__RDY;
  logic                 busy;
  logic                 done__ENA;
  logic [TAG_WIDTH-1:0] done_tag;
  logic [15:0]          done_count;
  logic [PEND_W-1:0]    pending;
  logic                 timeout_err;

  modport slave (
    input  request__ENA, request_tag, startSignal__RDY, busy,
    output request__RDY, startSignal__ENA, done__ENA, done_tag, done_count, pending, timeout_err
  );

  modport master (
    output request__ENA, request_tag, startSignal__RDY, busy,
    input  request__RDY, startSignal__ENA, done__ENA, done_tag, done_count, pending, timeout_err
  );
endinterface

// File: rtl/job_dispatcher.sv
// Queues tagged jobs and feeds them one at a time to a single-shot down-counter, reporting each completion.
// Optional watchdog under DISPATCH_TIMEOUT_EN forces completion of a job stuck busy for TIMEOUT_CYCLES.
module job_dispatcher #(
  parameter int DEPTH          = 4,
  parameter int TAG_WIDTH      = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic            CLK,
  input  logic            nRST,
  job_dispatcher_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic {IDLE, RUN} state_t;

  state_t               r_state, w_state_nxt;
  logic [AW:0]          r_wr_ptr, r_rd_ptr;
  logic [TAG_WIDTH-1:0] r_mem [DEPTH];
  logic [TAG_WIDTH-1:0] r_cur_tag, r_done_tag;
  logic [15:0]          r_done_count;

  logic w_full, w_empty, w_push, w_issue, w_complete, w_force;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  // Fullness is judged before any same-cycle pop, so a push at full is always dropped.
  assign w_push  = bus.request__ENA && !w_full;
  assign w_issue = !w_empty && bus.startSignal__RDY &&
                   ((r_state == IDLE) || ((r_state == RUN) && !bus.busy));
  assign w_complete = (r_state == RUN) && (!bus.busy || w_force);

  always_comb begin
    w_state_nxt = r_state;
    if (w_issue)
      w_state_nxt = RUN;
    else if (w_complete)
      w_state_nxt = IDLE;
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_state      <= IDLE;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_cur_tag    <= '0;
      r_done_tag   <= '0;
      r_done_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_push)
        r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_issue) begin
        r_rd_ptr  <= r_rd_ptr + 1'b1;
        r_cur_tag <= r_mem[r_rd_ptr[AW-1:0]];
      end
      if (w_complete) begin
        r_done_tag   <= r_cur_tag;
        r_done_count <= r_done_count + 16'd1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (w_push)
      r_mem[r_wr_ptr[AW-1:0]] <= bus.request_tag;
  end

`ifdef DISPATCH_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WW-1:0] TMO = WW'(TIMEOUT_CYCLES);

  logic [WW-1:0] r_wdog;
  logic          r_tmo_err, r_tmo_pend;

  // The limit is flagged one cycle, the forced completion lands the next.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_wdog     <= '0;
      r_tmo_err  <= 1'b0;
      r_tmo_pend <= 1'b0;
    end else begin
      if (w_issue)
        r_wdog <= '0;
      else if ((r_state == RUN) && bus.busy && (r_wdog != TMO))
        r_wdog <= r_wdog + 1'b1;
      if (w_complete)
        r_tmo_pend <= 1'b0;
      else if ((r_state == RUN) && (r_wdog == TMO)) begin
        r_tmo_pend <= 1'b1;
        r_tmo_err  <= 1'b1;
      end
    end
  end

  assign w_force         = r_tmo_pend;
  assign bus.timeout_err = r_tmo_err;
`else
  assign w_force         = 1'b0;
  assign bus.timeout_err = 1'b0;
`endif

  assign bus.request__RDY     = !w_full;
  assign bus.startSignal__ENA = w_issue;
  assign bus.done__ENA        = w_complete;
  assign bus.done_tag         = w_complete ? r_cur_tag : r_done_tag;
  assign bus.done_count       = r_done_count;
  assign bus.pending          = r_wr_ptr - r_rd_ptr;
endmodule

// File: tb/tb_job_dispatcher.sv
// Directed bench for job_dispatcher with a behavioural single-shot down-counter attached.
module tb_job_dispatcher;
  logic CLK = 1'b0;
  logic nRST = 1'b0;
  int checks = 0;
  int failures = 0;
  int cyc = 0;

  job_dispatcher_if #(.TAG_WIDTH(4), .PEND_W(3)) bus();

  job_dispatcher #(.DEPTH(4), .TAG_WIDTH(4), .TIMEOUT_CYCLES(8)) dut (
    .CLK(CLK), .nRST(nRST), .bus(bus)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // Counter model: loads max_amount-1 on start, counts to zero; force_busy pins it busy.
  logic [15:0] max_amount = 16'd22;
  logic [15:0] cnt = 16'd0;
  logic        force_busy = 1'b0;
  always @(posedge CLK) begin
    if (!nRST)                      cnt <= 16'd0;
    else if (bus.startSignal__ENA) cnt <= max_amount - 16'd1;
    else if (cnt != 16'd0)          cnt <= cnt - 16'd1;
  end
  assign bus.startSignal__RDY = (cnt == 16'd0) && !force_busy;
  assign bus.busy             = (cnt != 16'd0) || force_busy;

  int         done_cyc[$];
  logic [3:0] done_tags[$];
  int         start_cyc[$];
  always @(negedge CLK) begin
    if (bus.done__ENA === 1'b1) begin
      done_cyc.push_back(cyc);
      done_tags.push_back(bus.done_tag);
    end
    if (bus.startSignal__ENA === 1'b1) start_cyc.push_back(cyc);
  end

  task automatic clear_log();
    @(posedge CLK); #1;
    done_cyc.delete(); done_tags.delete(); start_cyc.delete();
  endtask

  task automatic do_reset();
    @(negedge CLK);
    nRST = 1'b0; bus.request__ENA = 1'b0; force_busy = 1'b0;
    repeat (2) @(negedge CLK);
    nRST = 1'b1;
  endtask

  task automatic test_reset();
    bus.request__ENA = 1'b0; bus.request_tag = 4'h0;
    repeat (3) @(negedge CLK);
    nRST = 1'b1;
    checks++; if (bus.request__RDY !== 1'b1) begin failures++; $display("FAIL reset_rdy: got %b expected 1", bus.request__RDY); end
    checks++; if (bus.startSignal__ENA !== 1'b0) begin failures++; $display("FAIL reset_start: got %b expected 0", bus.startSignal__ENA); end
    checks++; if (bus.done__ENA !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", bus.done__ENA); end
    checks++; if (bus.done_tag !== 4'h0) begin failures++; $display("FAIL reset_done_tag: got %h expected 0", bus.done_tag); end
    checks++; if (bus.pending !== 3'd0) begin failures++; $display("FAIL reset_pending: got %0d expected 0", bus.pending); end
    checks++; if (bus.done_count !== 16'h0) begin failures++; $display("FAIL reset_count: got %h expected 0", bus.done_count); end
    checks++; if (bus.timeout_err !== 1'b0) begin failures++; $display("FAIL reset_tmo: got %b expected 0", bus.timeout_err); end
  endtask

  task automatic test_single();
    int t0;
    int k;
    logic seen;
    do_reset();
    max_amount = 16'd22;
    @(negedge CLK); bus.request__ENA = 1'b1; bus.request_tag = 4'h5;
    @(negedge CLK); bus.request__ENA = 1'b0; t0 = cyc;
    checks++; if (bus.startSignal__ENA !== 1'b1) begin failures++; $display("FAIL single_start: got %b expected 1", bus.startSignal__ENA); end
    checks++; if (bus.pending !== 3'd1) begin failures++; $display("FAIL single_pending: got %0d expected 1", bus.pending); end
    seen = 1'b0; k = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge CLK);
      if (bus.done__ENA === 1'b1) begin seen = 1'b1; k = cyc - t0; end
    end
    checks++; if (!seen || k != 22) begin failures++; $display("FAIL single_latency: got seen=%b cycles=%0d expected 22", seen, k); end
    checks++; if (bus.done_tag !== 4'h5) begin failures++; $display("FAIL single_tag: got %h expected 5", bus.done_tag); end
    @(negedge CLK);
    checks++; if (bus.done__ENA !== 1'b0) begin failures++; $display("FAIL single_pulse: got %b expected 0", bus.done__ENA); end
    checks++; if (bus.done_count !== 16'd1) begin failures++; $display("FAIL single_count: got %0d expected 1", bus.done_count); end
    checks++; if (bus.done_tag !== 4'h5) begin failures++; $display("FAIL single_tag_hold: got %h expected 5", bus.done_tag); end
  endtask

  task automatic test_fill();
    do_reset();
    max_amount = 16'd22;
    force_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      checks++; if (bus.request__RDY !== 1'b1) begin failures++; $display("FAIL fill_rdy%0d: got %b expected 1", i, bus.request__RDY); end
      bus.request__ENA = 1'b1; bus.request_tag = 4'(i + 1);
    end
    @(negedge CLK); bus.request__ENA = 1'b0;
    checks++; if (bus.request__RDY !== 1'b0) begin failures++; $display("FAIL fill_full_rdy: got %b expected 0", bus.request__RDY); end
    checks++; if (bus.pending !== 3'd4) begin failures++; $display("FAIL fill_pending: got %0d expected 4", bus.pending); end
    checks++; if (bus.startSignal__ENA !== 1'b0) begin failures++; $display("FAIL fill_no_start: got %b expected 0", bus.startSignal__ENA); end
  endtask

  task automatic test_full_push_pop();
    int rel;
    clear_log();
    @(negedge CLK);
    force_busy = 1'b0; bus.request__ENA = 1'b1; bus.request_tag = 4'h9; rel = cyc;
    #1;
    checks++; if (bus.startSignal__ENA !== 1'b1) begin failures++; $display("FAIL pp_start: got %b expected 1", bus.startSignal__ENA); end
    checks++; if (bus.request__RDY !== 1'b0) begin failures++; $display("FAIL pp_rdy: got %b expected 0", bus.request__RDY); end
    @(negedge CLK); bus.request__ENA = 1'b0;
    checks++; if (bus.pending !== 3'd3) begin failures++; $display("FAIL pp_pending: got %0d expected 3", bus.pending); end
    repeat (4 * 22 + 40) @(negedge CLK);
    checks++; if (done_tags.size() != 4) begin failures++; $display("FAIL pp_ndone: got %0d expected 4", done_tags.size()); end
    if (done_tags.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        checks++; if (done_tags[i] !== 4'(i + 1)) begin failures++; $display("FAIL pp_order%0d: got %h expected %h", i, done_tags[i], i + 1); end
      end
      checks++; if (done_cyc[0] - rel != 22) begin failures++; $display("FAIL pp_first_lat: got %0d expected 22", done_cyc[0] - rel); end
      for (int i = 1; i < 4; i++) begin
        checks++; if (done_cyc[i] - done_cyc[i-1] != 22) begin failures++; $display("FAIL pp_gap%0d: got %0d expected 22", i, done_cyc[i] - done_cyc[i-1]); end
      end
    end
    checks++; if (bus.done_count !== 16'd4) begin failures++; $display("FAIL pp_count: got %0d expected 4", bus.done_count); end
    checks++; if (bus.pending !== 3'd0) begin failures++; $display("FAIL pp_drained: got %0d expected 0", bus.pending); end
  endtask

  task automatic test_reset_mid_job();
    max_amount = 16'd22;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK); bus.request__ENA = 1'b1; bus.request_tag = 4'(10 + i);
    end
    @(negedge CLK); bus.request__ENA = 1'b0;
    checks++; if (bus.pending !== 3'd2) begin failures++; $display("FAIL mid_queued: got %0d expected 2", bus.pending); end
    repeat (8) @(negedge CLK);
    nRST = 1'b0;
    @(negedge CLK); nRST = 1'b1;
    checks++; if (bus.pending !== 3'd0) begin failures++; $display("FAIL mid_pending: got %0d expected 0", bus.pending); end
    checks++; if (bus.done_count !== 16'd0) begin failures++; $display("FAIL mid_count: got %0d expected 0", bus.done_count); end
    checks++; if (bus.request__RDY !== 1'b1) begin failures++; $display("FAIL mid_rdy: got %b expected 1", bus.request__RDY); end
    clear_log();
    repeat (80) @(negedge CLK);
    checks++; if (done_tags.size() != 0) begin failures++; $display("FAIL mid_no_done: got %0d expected 0", done_tags.size()); end
    checks++; if (start_cyc.size() != 0) begin failures++; $display("FAIL mid_no_start: got %0d expected 0", start_cyc.size()); end
  endtask

  task automatic test_timeout();
    logic seen;
    clear_log();
    max_amount = 16'd22;
    @(negedge CLK); bus.request__ENA = 1'b1; bus.request_tag = 4'h7;
    @(negedge CLK); bus.request__ENA = 1'b0;
    @(negedge CLK); force_busy = 1'b1;
`ifdef DISPATCH_TIMEOUT_EN
    repeat (30) @(negedge CLK);
    checks++; if (bus.timeout_err !== 1'b1) begin failures++; $display("FAIL tmo_err: got %b expected 1", bus.timeout_err); end
    checks++; if (done_tags.size() != 1) begin failures++; $display("FAIL tmo_forced: got %0d expected 1", done_tags.size()); end
    else begin
      checks++; if (done_tags[0] !== 4'h7) begin failures++; $display("FAIL tmo_tag: got %h expected 7", done_tags[0]); end
    end
    force_busy = 1'b0;
`else
    repeat (40) @(negedge CLK);
    checks++; if (done_tags.size() != 0) begin failures++; $display("FAIL tmo_waits: got %0d expected 0", done_tags.size()); end
    checks++; if (bus.timeout_err !== 1'b0) begin failures++; $display("FAIL tmo_err: got %b expected 0", bus.timeout_err); end
    force_busy = 1'b0; #1;
    seen = bus.done__ENA;
    for (int i = 0; i < 5 && !seen; i++) begin
      @(negedge CLK); seen = bus.done__ENA;
    end
    checks++; if (seen !== 1'b1 || bus.done_tag !== 4'h7) begin failures++; $display("FAIL tmo_release: got done=%b tag=%h expected 1/7", seen, bus.done_tag); end
`endif
    repeat (3) @(negedge CLK);
    checks++; if (bus.done_count !== 16'd1) begin failures++; $display("FAIL tmo_count: got %0d expected 1", bus.done_count); end
  endtask

  task automatic test_wrap();
    int n;
    do_reset();
    max_amount = 16'd1;
    n = 0;
    while (n < 65535) begin
      @(negedge CLK);
      if (bus.request__RDY === 1'b1) begin bus.request__ENA = 1'b1; bus.request_tag = 4'(n); n++; end
      else bus.request__ENA = 1'b0;
    end
    @(negedge CLK); bus.request__ENA = 1'b0;
    repeat (5) @(negedge CLK);
    checks++; if (bus.done_count !== 16'hFFFF) begin failures++; $display("FAIL wrap_preload: got %h expected ffff", bus.done_count); end
    checks++; if (bus.pending !== 3'd0) begin failures++; $display("FAIL wrap_pending: got %0d expected 0", bus.pending); end
    @(negedge CLK); bus.request__ENA = 1'b1; bus.request_tag = 4'h3;
    @(negedge CLK); bus.request__ENA = 1'b0;
    repeat (4) @(negedge CLK);
    checks++; if (bus.done_count !== 16'h0000) begin failures++; $display("FAIL wrap_zero: got %h expected 0000", bus.done_count); end
    checks++; if (bus.done_tag !== 4'h3) begin failures++; $display("FAIL wrap_tag: got %h expected 3", bus.done_tag); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_full_push_pop();
    test_reset_mid_job();
    test_timeout();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/job_dispatcher.md
Name: job_dispatcher

Overview:
- Upstream feeder for the single-shot down-counter stage: queues tagged start requests from a client, issues one startSignal to the counter when it is idle, and reports completion per job.
- Completion is detected from the counter's busy output.
- Sits between the client request channel and the counter's startSignal__ENA/__RDY and busy ports.
- Shares CLK/nRST with the counter.

Parameters:
- DEPTH, 4, request FIFO entries; power of two, 2..16.
- TAG_WIDTH, 4, width of the job tag carried from request to completion.
- TIMEOUT_CYCLES, 64, watchdog limit in cycles while RUN; used only with the optional feature.

Ports:
- CLK  input  1  clock; all state updates on posedge.
- nRST  input  1  reset; synchronous, active-low.
- request__ENA  input  1  enqueue request; legal only when request__RDY=1.
- request_tag  input  TAG_WIDTH  tag of the enqueued job.
- request__RDY  output  1  FIFO not full.
- startSignal__ENA  output  1  start pulse to the counter.
- startSignal__RDY  input  1  counter idle (counter==0).
- busy  input  1  counter running.
- done__ENA  output  1  one-cycle completion pulse.
- done_tag  output  TAG_WIDTH  tag of the completed job; valid when done__ENA=1.
- done_count  output  16  completed-job count; wraps 0xFFFF->0.
- pending  output  3+  FIFO occupancy, clog2(DEPTH)+1 bits.
- timeout_err  output  1  sticky watchdog flag; 0 when the feature is disabled.

Behaviour:
- Reset (nRST=0 at posedge):
  - FIFO emptied.
  - FSM to IDLE.
  - cur_tag=0, done_count=0, timeout_err=0, watchdog=0.
  - Combinational outputs then read: request__RDY=1, startSignal__ENA=0, done__ENA=0, done_tag=0, pending=0.
  - Reset mid-job drops the in-flight job and all queued jobs. No done__ENA is issued for them.
- FIFO:
  - Registered, DEPTH entries, wrapping read/write pointers with an extra wrap bit.
  - Push when request__ENA && request__RDY.
  - request__RDY = !full. A push while full is rejected even if a pop occurs in the same cycle.
  - Simultaneous push and pop when non-empty leaves occupancy unchanged.
  - No bypass: a request accepted at cycle t can start at t+1 at the earliest.
- FSM states: IDLE, RUN.
  - issue = fifo_nonempty && startSignal__RDY && (state==IDLE || (state==RUN && !busy)).
  - startSignal__ENA = issue (combinational). It is never asserted while startSignal__RDY=0.
  - On issue: pop the head, cur_tag <= head tag, state <= RUN.
  - RUN is entered the cycle after the start. The counter loads MAX_AMOUNT-1 at that edge.
  - RUN && !busy means the job is complete:
    - done__ENA=1 and done_tag=cur_tag that cycle.
    - done_count increments by 1, modulo 2^16.
    - Next state is RUN if a new issue occurs in the same cycle (back-to-back), else IDLE.
  - MAX_AMOUNT=1 (busy never rises): completion is reported in the first RUN cycle.
  - busy is ignored in IDLE.
- Latency: request accepted at t with an empty FIFO and idle counter:
  - startSignal__ENA at t+1.
  - done__ENA at t+1+MAX_AMOUNT.
  - Back-to-back jobs are spaced exactly MAX_AMOUNT cycles apart.
- done_tag holds its last value when done__ENA=0.

Optional Feature:
- Macro: DISPATCH_TIMEOUT_EN.
- Defined:
  - A watchdog counter clears on every issue and increments each RUN cycle while busy=1.
  - When it reaches TIMEOUT_CYCLES, timeout_err <= 1 (sticky until reset) and the FSM forces completion the next cycle: done__ENA with cur_tag, done_count++.
- Undefined: no watchdog logic; timeout_err is tied to 0.

Test Plan:
- Reset, then a single request with tag 0x5 and counter MAX_AMOUNT=22 -> startSignal__ENA 1 cycle later; done__ENA with done_tag=0x5 22 cycles after the start; done_count=1.
- Enqueue 4 tags 1,2,3,4 in consecutive cycles (DEPTH=4) -> request__RDY stays 1 through the 4th push, then is 0 with pending=4; completions in order 1,2,3,4, 22 cycles apart; done_count=4.
- Full FIFO with push and pop in the same cycle -> push rejected; pending drops 4->3; the dropped tag never completes.
- Assert nRST=0 for 1 cycle 10 cycles into a job with 2 queued -> no done__ENA afterwards; pending=0, done_count=0, request__RDY=1.
- Preload done_count to 0xFFFF via 65535 jobs at MAX_AMOUNT=1 -> the next completion wraps done_count to 0x0000.
- With DISPATCH_TIMEOUT_EN, TIMEOUT_CYCLES=8, busy held at 1 -> timeout_err=1 after 8 RUN cycles and a forced done__ENA with the current tag; without the macro, timeout_err stays 0 and the dispatcher waits indefinitely.
